chip8_timers: RTL and testbench

Delay and sound timer unit for the CHIP-8 core, placed directly downstream of the 60 Hz clock divider. It samples the divided clock level as a data input in the system clock domain and turns each rising edge into a one-cycle tick. On each tick it decrements the 8-bit delay timer (DT) and sound timer (ST), each saturating at zero. It also produces a buzzer square wave while ST is non-zero.

---
 rtl/chip8_timers.sv | 66 ++++++
 tb/tb_chip8_timers.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/chip8_timers.sv
// CHIP-8 delay/sound timers: 60 Hz edge detect, saturating DT/ST countdown, buzzer tone.
// Loads and decrements are visible the cycle after the edge; no backpressure, inputs are accepted every cycle.
module chip8_timers #(
   parameter int TONE_DIVISOR = 4
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic       tick_in,
   input  logic       dt_we,
   input  logic       st_we,
   input  logic [7:0] wdata,
   output logic [7:0] dt_out,
   output logic       st_active,
   output logic       tick_out,
   output logic       tone_out
);

   localparam int CW = (TONE_DIVISOR > 1) ? $clog2(TONE_DIVISOR) : 1;
   localparam logic [CW-1:0] TONE_LAST = CW'(TONE_DIVISOR - 1);
   localparam logic [CW-1:0] TONE_HALF = CW'(TONE_DIVISOR / 2);

   logic          tick_q;
   logic          tick;
   logic [7:0]    dt_q;
   logic [7:0]    st_q;
   logic [CW-1:0] tone_cnt;

   // tick_q resets high so a level already high at reset release is not an edge
   assign tick = tick_in & ~tick_q;

   always_ff @(posedge clk_in) begin
      if (rst) begin
         tick_q   <= 1'b1;
         tick_out <= 1'b0;
         dt_q     <= 8'd0;
         st_q     <= 8'd0;
         tone_cnt <= '0;
      end else begin
         tick_q   <= tick_in;
         tick_out <= tick;

         if (dt_we)
            dt_q <= wdata;
         else if (tick && dt_q != 8'd0)
            dt_q <= dt_q - 8'd1;

         if (st_we)
            st_q <= wdata;
         else if (tick && st_q != 8'd0)
            st_q <= st_q - 8'd1;

         // Counter idles at zero so the tone phase restarts high on each new sound
         if (st_q == 8'd0)
            tone_cnt <= '0;
         else if (tone_cnt == TONE_LAST)
            tone_cnt <= '0;
         else
            tone_cnt <= tone_cnt + 1'b1;
      end
   end

   assign dt_out    = dt_q;
   assign st_active = (st_q != 8'd0);
   assign tone_out  = st_active & (tone_cnt < TONE_HALF);

endmodule

// File: tb/tb_chip8_timers.sv
// Scoreboard bench for chip8_timers: stimulus pushes model predictions, monitor pops and compares.
module tb_chip8_timers;

   localparam int TD = 4;

   logic       clk_in = 1'b0;
   logic       rst = 1'b1;
   logic       tick_in = 1'b1;
   logic       dt_we = 1'b0;
   logic       st_we = 1'b0;
   logic [7:0] wdata = 8'd0;
   logic [7:0] dt_out;
   logic       st_active;
   logic       tick_out;
   logic       tone_out;

   chip8_timers #(.TONE_DIVISOR(TD)) dut (
      .clk_in   (clk_in),
      .rst      (rst),
      .tick_in  (tick_in),
      .dt_we    (dt_we),
      .st_we    (st_we),
      .wdata    (wdata),
      .dt_out   (dt_out),
      .st_active(st_active),
      .tick_out (tick_out),
      .tone_out (tone_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [7:0] dt;
      logic       sa;
      logic       to;
      logic       tn;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   ticks_seen = 0;

   // Reference model state: timer values as integers, run = cycles ST has been non-zero
   int m_dt = 0, m_st = 0, m_run = 0;
   bit m_prev = 1'b1, m_tickout = 1'b0;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Monitor: outputs are compared every cycle, 1 time unit after the edge
   always begin
      exp_t e;
      @(posedge clk_in);
      #1;
      if (tick_out === 1'b1) ticks_seen++;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("dt_out", int'(dt_out), int'(e.dt));
         chk("st_active", int'(st_active), int'(e.sa));
         chk("tick_out", int'(tick_out), int'(e.to));
         chk("tone_out", int'(tone_out), int'(e.tn));
      end
   end

   task automatic drive(input bit r, input bit t, input bit dw, input bit sw, input logic [7:0] wd);
      exp_t e;
      bit   tk;
      int   old_st;
      @(posedge clk_in);
      #2;
      rst = r; tick_in = t; dt_we = dw; st_we = sw; wdata = wd;
      if (r) begin
         m_dt = 0; m_st = 0; m_run = 0; m_prev = 1'b1; m_tickout = 1'b0;
      end else begin
         tk = t && !m_prev;
         old_st = m_st;
         m_prev = t;
         m_tickout = tk;
         if (dw) m_dt = int'(wd);
         else if (tk && m_dt > 0) m_dt = m_dt - 1;
         if (sw) m_st = int'(wd);
         else if (tk && m_st > 0) m_st = m_st - 1;
         if (m_st != 0) m_run = (old_st == 0) ? 0 : m_run + 1;
      end
      e.dt = 8'(m_dt);
      e.sa = (m_st != 0);
      e.to = m_tickout;
      e.tn = (m_st != 0) && ((m_run % TD) < TD / 2);
      q.push_back(e);
   endtask

   task automatic idle(input bit t);
      drive(1'b0, t, 1'b0, 1'b0, 8'd0);
   endtask

   initial begin
      int   snap;
      bit   tk_lvl;
      logic [7:0] pat;

      // Reset with tick_in high, then hold high: no tick
      repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
      snap = ticks_seen;
      repeat (10) idle(1'b1);
      idle(1'b1);
      chk("hold_high_no_tick", ticks_seen - snap, 0);
      chk("hold_high_dt", int'(dt_out), 0);

      // Load 3 then four rising edges: 2,1,0,0 with a pulse each
      drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd3);
      snap = ticks_seen;
      for (int i = 0; i < 4; i++) begin
         idle(1'b0); idle(1'b0); idle(1'b1); idle(1'b1);
      end
      idle(1'b0);
      chk("countdown_pulses", ticks_seen - snap, 4);
      chk("countdown_no_wrap", int'(dt_out), 0);

      // Load coinciding with a tick wins
      drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd5);
      idle(1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 8'd9);
      idle(1'b1);
      chk("load_beats_tick", int'(dt_out), 9);
      idle(1'b0); idle(1'b1); idle(1'b0);
      chk("after_load_tick", int'(dt_out), 8);

      // Tone pattern 1,1,0,0 from the write edge
      idle(1'b0); idle(1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'd2);
      pat = 8'b00110011;
      for (int i = 0; i < 8; i++) begin
         idle(1'b0);
         chk("tone_pattern", int'(tone_out), int'(pat[i]));
      end
      idle(1'b1); idle(1'b0); idle(1'b1); idle(1'b0);
      chk("st_expired_active", int'(st_active), 0);
      chk("st_expired_tone", int'(tone_out), 0);

      // Reset mid-countdown
      drive(1'b0, 1'b0, 1'b1, 1'b1, 8'd7);
      idle(1'b0); idle(1'b1);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
      idle(1'b1);
      chk("rst_dt", int'(dt_out), 0);
      chk("rst_st_active", int'(st_active), 0);
      chk("rst_tone", int'(tone_out), 0);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 8'd7);
      repeat (5) idle(1'b1);
      chk("post_rst_no_tick", int'(dt_out), 7);
      idle(1'b0); idle(1'b1); idle(1'b0);
      chk("post_rst_fresh_edge", int'(dt_out), 6);

      // Long high level gives one decrement
      idle(1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd10);
      snap = ticks_seen;
      repeat (50) idle(1'b1);
      idle(1'b0); idle(1'b0);
      chk("long_high_dt", int'(dt_out), 9);
      chk("long_high_pulses", ticks_seen - snap, 1);

      // Randomized traffic
      tk_lvl = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         bit r, dw, sw;
         logic [7:0] wd;
         if ($urandom_range(0, 3) == 0) tk_lvl = ~tk_lvl;
         r  = ($urandom_range(0, 99) == 0);
         dw = ($urandom_range(0, 15) == 0);
         sw = ($urandom_range(0, 15) == 0);
         wd = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
         drive(r, tk_lvl, dw, sw, wd);
      end

      // Drain the scoreboard with a bounded wait
      idle(1'b0);
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk_in);
      #3;
      chk("scoreboard_drained", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
